// File: rtl/ats21_pkg.sv
// ats21_pkg: shared sizes and event type for the ATS21 alarm event queue.
// evt_t carries a timestamp only when ATS_EVT_TIMESTAMP_EN is defined.
package ats21_pkg;
  localparam int NUM_ALARMS = 24;
  localparam int ALARM_ID_W = 5;
  localparam int TS_W = 16;
  localparam int EVT_FIFO_DEPTH = 8;
  typedef struct packed {
    logic [ALARM_ID_W-1:0] id;
`ifdef ATS_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } evt_t;
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: registered-storage event FIFO with push/pop/count; read data comes from storage only.
module evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/alarm_event_queue.sv
// alarm_event_queue: turns ATS21 alarm-finished rises into a prioritised event queue.
// Optional per-event timestamps are enabled with ATS_EVT_TIMESTAMP_EN.
module alarm_event_queue
  import ats21_pkg::*;
#(
  parameter int NUM_ALARMS = ats21_pkg::NUM_ALARMS,
  parameter int FIFO_DEPTH = EVT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_ALARMS-1:0]       alarm_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [ALARM_ID_W-1:0]       evt_id,
`ifdef ATS_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]             evt_ts,
`endif
  output logic [NUM_ALARMS-1:0]       pending,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  logic [NUM_ALARMS-1:0] prev, rise, clr;
  logic [ALARM_ID_W-1:0] sel;
  logic push, pop, full, empty;
  evt_t wdata, rdata;
  assign rise = alarm_data & ~prev;
  assign evt_valid = !empty;
  assign pop = evt_valid && evt_ready;
  assign push = |pending && (!full || pop);
  always_comb begin
    sel = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (pending[i]) sel = ALARM_ID_W'(i);
  end
  assign clr = push ? NUM_ALARMS'(1) << sel : '0;
  // a rise on a bit still waiting merges into it and marks the loss
  always_ff @(posedge clk)
    if (!reset) begin
      prev <= '0;
      pending <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= alarm_data;
      pending <= (pending & ~clr) | rise;
      overflow <= |(rise & pending & ~clr) | (overflow & ~clr_overflow);
    end
`ifdef ATS_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_store [NUM_ALARMS];
  always_ff @(posedge clk)
    ts_cnt <= !reset ? '0 : ts_cnt + 1'b1;
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_ALARMS; i++)
      if (rise[i]) ts_store[i] <= ts_cnt;
  assign wdata = '{id: sel, ts: ts_store[sel]};
  assign evt_ts = rdata.ts;
`else
  assign wdata = '{id: sel};
`endif
  assign evt_id = rdata.id;
  evt_fifo #(
    .WIDTH($bits(evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .wdata(wdata),
    .pop(pop),
    .rdata(rdata),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/alarm_event_queue.md
ALARM_EVENT_QUEUE -- requirements
Module: alarm_event_queue

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 24, number of alarm finished lines from the ATS21 data bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event queue entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port alarm_data  input  NUM_ALARMS  ATS21 data bus; bit i is alarm i finished, held high 2 cycles per event.
REQ-006 SHALL have port evt_valid  output  1  queue head holds an event.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts head this cycle.
REQ-008 SHALL have port evt_id  output  5  alarm index of head event.
REQ-009 SHALL have port evt_ts  output  16  head event timestamp; present only with ATS_EVT_TIMESTAMP_EN.
REQ-010 SHALL have port pending  output  NUM_ALARMS  detected events not yet queued.
REQ-011 SHALL have port overflow  output  1  sticky lost-event flag.
REQ-012 SHALL have port clr_overflow  input  1  clears overflow.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-014 SHALL register alarm_data into prev each cycle; rise[i] = alarm_data[i] & ~prev[i].
REQ-015 SHALL set pending[i] on rise[i]; set SHALL win over a same-cycle clear of the same bit.
REQ-016 SHALL each cycle select the lowest-index pending bit and push it, clearing that bit, when fifo_count < FIFO_DEPTH or a pop occurs the same cycle.
REQ-017 SHALL push at most one event per cycle; other pending bits wait, with no loss.
REQ-018 SHALL pop when evt_valid && evt_ready; evt_valid = (fifo_count != 0).
REQ-019 SHALL hold evt_id/evt_ts stable while evt_valid && !evt_ready.
REQ-020 SHALL, when full with no pop, hold all pending bits and push nothing.
REQ-021 SHALL set overflow when rise[i] occurs while pending[i] is already 1 and not being cleared that cycle; the event merges into the pending bit.
REQ-022 SHALL clear overflow on clr_overflow; a same-cycle set SHALL win.
REQ-023 SHALL give latency: alarm_data[i] first high in cycle N, FIFO empty, no lower pending bits gives evt_valid high in cycle N+2 with evt_id = i.
REQ-024 SHALL, on simultaneous push and pop, leave fifo_count unchanged, including when full.

Reset
REQ-025 SHALL, with reset low at posedge, clear prev, pending, overflow, FIFO pointers, fifo_count and timestamp counter; evt_valid = 0 from the next cycle.
REQ-026 SHALL discard queued and pending events on reset mid-operation; alarm bits high after reset release count as rises.

Configuration
REQ-027 SHALL, with ATS_EVT_TIMESTAMP_EN defined, run a 16-bit free-running counter (wraps 0xFFFF to 0x0000), capture it per bit on rise[i], and carry it with the event to evt_ts.
REQ-028 SHALL, without ATS_EVT_TIMESTAMP_EN, omit evt_ts, the counter and per-bit timestamp storage; all other behaviour is identical.

Structure
REQ-029 SHALL take NUM_ALARMS, ALARM_ID_W (5), TS_W (16), EVT_FIFO_DEPTH and the evt_t struct (id, optional ts) from shared package ats21_pkg.
REQ-030 SHALL implement the queue as sub-module evt_fifo (parameterised width/depth, push/pop/count, no flow-through).

Verification
REQ-031 SHALL cover: alarm_data[5] high 2 cycles from cycle 10, evt_ready=1 -> evt_valid at cycle 12, evt_id=5, single event.
REQ-032 SHALL cover: bits 3, 0 and 20 rising in one cycle -> events popped in order 0, 3, 20 on consecutive cycles.
REQ-033 SHALL cover: evt_ready=0, 9 distinct alarms fire -> fifo_count=8, pending has 1 bit; one pop -> that bit is queued next cycle; overflow=0.
REQ-034 SHALL cover: alarm 7 fires twice while held pending (queue full) -> overflow=1; clr_overflow pulse -> 0.
REQ-035 SHALL cover: reset low with 4 queued events -> evt_valid=0, fifo_count=0, pending=0 next cycle.
REQ-036 SHALL cover, with ATS_EVT_TIMESTAMP_EN: counter at 0xFFFE, rises one cycle apart -> evt_ts 0xFFFE then 0xFFFF, then 0x0000 on wrap.
